keypad_time_entry: RTL and testbench
====================================

Name: keypad_time_entry

Overview:
- Front-end stage directly upstream of the `microwave` countdown/display controller.
- Samples the raw 10-key one-hot keypad and debounces it.
- Converts each accepted keystroke to a BCD digit and shifts it into a 3-digit M:SS entry buffer.
- The controller reads the buffer and pulses `take` when start is accepted, which empties the buffer for the next entry.

Parameters:
- DEBOUNCE_CYCLES, 2: consecutive identical synchronised samples required to accept a press or a release (min 1).
- MAX_SEC_TENS, 5: largest legal seconds-tens digit, used for `time_valid`.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- kbd  in  10  raw keypad; bit n high = digit n pressed
- clear  in  1  synchronous active-high buffer clear (controller's clear key, already inverted)
- entry_en  in  1  high while the controller accepts digit entry (not cooking)
- take  in  1  one-cycle pulse: controller has loaded the buffer
- min_bcd  out  4  minutes digit
- sec_tens_bcd  out  4  seconds-tens digit
- sec_ones_bcd  out  4  seconds-ones digit
- digit_cnt  out  2  digits entered, saturating at 3
- time_valid  out  1  buffer nonzero and sec_tens_bcd <= MAX_SEC_TENS
- key_strobe  out  1  one-cycle pulse on each accepted keystroke
- key_code  out  4  BCD of the last accepted key

Behaviour:
- Input sync: `kbd` is registered once into `kbd_q`. All decoding uses `kbd_q`.
- Decode: `kbd_q` one-hot → digit 0-9. Zero → NONE. More than one bit set → MULTI.
- FSM states are IDLE, PRESS_DB, HELD, RELEASE_DB and BLOCKED.
- IDLE:
  - One-hot → PRESS_DB. Load `cand` := digit; debounce counter := 1.
  - MULTI → BLOCKED.
  - NONE → stay in IDLE.
- PRESS_DB:
  - Sample equals `cand` → counter increments.
  - When the counter reaches DEBOUNCE_CYCLES → accept the key and go to HELD.
  - Sample differs (including NONE) → IDLE, with no accept.
  - MULTI → BLOCKED.
  - With DEBOUNCE_CYCLES = 1, the accept happens on the IDLE→PRESS_DB edge itself; PRESS_DB is bypassed and the FSM goes straight to HELD.
- HELD: NONE → RELEASE_DB with counter := 1. Any other sample → stay in HELD; there is no auto-repeat.
- RELEASE_DB:
  - NONE for DEBOUNCE_CYCLES consecutive samples → IDLE.
  - Any non-NONE sample → HELD.
- BLOCKED: stays until NONE for DEBOUNCE_CYCLES consecutive samples, then IDLE. No accept.
- Accept action, all on the same edge:
  - `key_strobe` = 1 for one cycle.
  - `key_code` := `cand`.
  - If `entry_en`: shift `min_bcd` ← `sec_tens_bcd` ← `sec_ones_bcd` ← `cand`, and `digit_cnt` := min(`digit_cnt`+1, 3).
  - If `entry_en` = 0: strobe and code still update; the buffer is unchanged.
- Latency: a clean press held from the edge that samples it into `kbd_q` produces its digit and strobe DEBOUNCE_CYCLES edges later. With the default (2), that is 3 clk edges after `kbd` changes.
- Overflow: a 4th or later digit keeps shifting, so the oldest digit is lost. Entering 1,2,3,4 gives 2:34.
- Priority per edge: reset > clear > take > accept.
  - reset: buffer = 0, `digit_cnt` = 0, `key_code` = 0, `key_strobe` = 0, FSM = IDLE, `kbd_q` = 0.
  - clear: buffer = 0 and `digit_cnt` = 0. The FSM is unaffected; an accept on the same edge is dropped.
  - take: buffer and `digit_cnt` are zeroed. If an accept with `entry_en` coincides, the result is `sec_ones_bcd` = `cand`, other digits 0, `digit_cnt` = 1.
- `time_valid` is combinational from the buffer. The digits 0:00 give `time_valid` = 0; 0:75 gives 0.
- Reset mid-press: the FSM returns to IDLE. A key still held is seen as a new press after the debounce window (it is re-sampled).

Decomposition:
- Shared package holds:
  - `KEY_NONE` code.
  - FSM state encoding.
  - `DIGIT_W` = 4.
  - `NUM_KEYS` = 10.
- One sub-module, `key_debouncer`: sync register, one-hot decode, FSM, and the `key_strobe`/`key_code` outputs.
- The top module holds the BCD shift buffer, `digit_cnt` and `time_valid`.

Test Plan:
- Reset, then press 1, release, press 2, release (each level held ≥4 cycles, `entry_en` = 1) → two `key_strobe` pulses; buffer 0:12, `digit_cnt` = 2, `time_valid` = 1.
- Press 1,2,9 then pulse `take` → buffer 1:29 before `take`. After `take`: 0:00, `digit_cnt` = 0, `time_valid` = 0.
- Glitch: bit 3 high for 1 cycle then low (DEBOUNCE_CYCLES = 2) → no strobe, buffer unchanged. Bits 3 and 5 held together, then released → no strobe, FSM passes through BLOCKED back to IDLE.
- Hold 5 for 20 cycles → exactly one strobe, `key_code` = 5. A release bounce (0,5,0,0) → still only one strobe.
- `entry_en` = 0, press 7 → strobe with `key_code` = 7, buffer unchanged. Then 1,2,3,4 with `entry_en` = 1 → 2:34, `digit_cnt` = 3. Then 7,5 → 4:75 with `time_valid` = 0.
- Simultaneous events:
  - `clear` on the accept edge → buffer 0:00.
  - `take` on the accept edge of key 8 → 0:08, `digit_cnt` = 1.
  - `reset` while 6 is held → outputs zero, then one strobe for 6 after DEBOUNCE_CYCLES+1 edges.

Source files
------------

// File: rtl/keypad_time_entry_pkg.sv
// Shared types and constants for the keypad time-entry front end.
// Provides the key-code encoding, the debouncer state encoding and the one-hot decoder.
package keypad_time_entry_pkg;

    localparam int DIGIT_W  = 4;
    localparam int NUM_KEYS = 10;

    localparam logic [DIGIT_W-1:0] KEY_NONE  = 4'hF;
    localparam logic [DIGIT_W-1:0] KEY_MULTI = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_HELD       = 3'd2,
        ST_RELEASE_DB = 3'd3,
        ST_BLOCKED    = 3'd4
    } kbd_state_t;

    // One-hot keypad vector to digit; no key gives KEY_NONE and chords give KEY_MULTI.
    function automatic logic [DIGIT_W-1:0] decode_key(input logic [NUM_KEYS-1:0] keys);
        logic [DIGIT_W-1:0] code;
        int unsigned        ones;
        code = KEY_NONE;
        ones = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keys[i]) begin
                ones = ones + 1;
                code = DIGIT_W'(i);
            end
        end
        if (ones > 1) begin
            code = KEY_MULTI;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_time_entry_debouncer.sv
// Keypad sampler and debouncer: one sync register, one-hot decode and the press/release FSM.
// Exposes the combinational accept for the entry buffer plus registered strobe/code outputs.
module key_debouncer
    import keypad_time_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] kbd,
    output logic                accept,
    output logic [DIGIT_W-1:0]  accept_code,
    output logic                key_strobe,
    output logic [DIGIT_W-1:0]  key_code
);

    localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_KEYS-1:0] kbd_q;
    kbd_state_t          state, state_n;
    logic [DIGIT_W-1:0]  cand, cand_n;
    logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
    logic [DIGIT_W-1:0]  sample;
    logic                is_none, is_multi, is_digit;

    assign sample   = decode_key(kbd_q);
    assign is_none  = (sample == KEY_NONE);
    assign is_multi = (sample == KEY_MULTI);
    assign is_digit = !is_none && !is_multi;
    assign cnt_inc  = cnt + CNT_ONE;

    // Next-state logic; the counter tracks consecutive matching samples in the current state.
    always_comb begin
        state_n     = state;
        cand_n      = cand;
        cnt_n       = cnt;
        accept      = 1'b0;
        accept_code = cand;
        case (state)
            ST_IDLE: begin
                if (is_digit) begin
                    cand_n      = sample;
                    accept_code = sample;
                    cnt_n       = CNT_ONE;
                    if (DB_LAST == CNT_ONE) begin
                        accept  = 1'b1;
                        state_n = ST_HELD;
                    end else begin
                        state_n = ST_PRESS_DB;
                    end
                end else if (is_multi) begin
                    cnt_n   = '0;
                    state_n = ST_BLOCKED;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PRESS_DB: begin
                if (is_multi) begin
                    cnt_n   = '0;
                    state_n = ST_BLOCKED;
                end else if (sample == cand) begin
                    if (cnt_inc == DB_LAST) begin
                        accept  = 1'b1;
                        state_n = ST_HELD;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (is_none) begin
                    cnt_n   = CNT_ONE;
                    state_n = (DB_LAST == CNT_ONE) ? ST_IDLE : ST_RELEASE_DB;
                end else begin
                    state_n = ST_HELD;
                end
            end
            ST_RELEASE_DB: begin
                if (!is_none) begin
                    state_n = ST_HELD;
                end else if (cnt_inc == DB_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_BLOCKED: begin
                if (!is_none) begin
                    cnt_n = '0;
                end else if (cnt_inc == DB_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Sync register, FSM state and the registered keystroke outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_q      <= '0;
            state      <= ST_IDLE;
            cand       <= '0;
            cnt        <= '0;
            key_strobe <= 1'b0;
            key_code   <= '0;
        end else begin
            kbd_q      <= kbd;
            state      <= state_n;
            cand       <= cand_n;
            cnt        <= cnt_n;
            key_strobe <= accept;
            if (accept) begin
                key_code <= accept_code;
            end
        end
    end

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time-entry top: debounced keystrokes shifted into a 3-digit M:SS BCD buffer.
// The downstream controller reads the buffer and empties it with take or clear.
module keypad_time_entry
    import keypad_time_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int MAX_SEC_TENS    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] kbd,
    input  logic                clear,
    input  logic                entry_en,
    input  logic                take,
    output logic [DIGIT_W-1:0]  min_bcd,
    output logic [DIGIT_W-1:0]  sec_tens_bcd,
    output logic [DIGIT_W-1:0]  sec_ones_bcd,
    output logic [1:0]          digit_cnt,
    output logic                time_valid,
    output logic                key_strobe,
    output logic [DIGIT_W-1:0]  key_code
);

    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = DIGIT_W'(MAX_SEC_TENS);

    logic               accept;
    logic [DIGIT_W-1:0] accept_code;
    logic               shift_in;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk        (clk),
        .reset      (reset),
        .kbd        (kbd),
        .accept     (accept),
        .accept_code(accept_code),
        .key_strobe (key_strobe),
        .key_code   (key_code)
    );

    assign shift_in = accept && entry_en;

    // Entry buffer: clear beats take, and a take coinciding with a keystroke restarts from that digit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            min_bcd      <= '0;
            sec_tens_bcd <= '0;
            sec_ones_bcd <= '0;
            digit_cnt    <= 2'd0;
        end else if (take) begin
            min_bcd      <= '0;
            sec_tens_bcd <= '0;
            sec_ones_bcd <= shift_in ? accept_code : '0;
            digit_cnt    <= shift_in ? 2'd1 : 2'd0;
        end else if (shift_in) begin
            min_bcd      <= sec_tens_bcd;
            sec_tens_bcd <= sec_ones_bcd;
            sec_ones_bcd <= accept_code;
            digit_cnt    <= (digit_cnt == 2'd3) ? 2'd3 : digit_cnt + 2'd1;
        end
    end

    assign time_valid = (|{min_bcd, sec_tens_bcd, sec_ones_bcd}) && (sec_tens_bcd <= SEC_TENS_MAX);

endmodule

// File: tb/tb_keypad_time_entry.sv
// Self-checking bench for keypad_time_entry: a scoreboard holds the expected key/buffer
// state for every keystroke, and each scenario task checks the settled buffer inline.
module tb_keypad_time_entry;
    import keypad_time_entry_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  kbd = 10'd0;
    logic        clear = 1'b0;
    logic        entry_en = 1'b1;
    logic        take = 1'b0;
    logic [3:0]  min_bcd, sec_tens_bcd, sec_ones_bcd, key_code;
    logic [1:0]  digit_cnt;
    logic        time_valid, key_strobe;

    keypad_time_entry #(.DEBOUNCE_CYCLES(2), .MAX_SEC_TENS(5)) dut (
        .clk(clk), .reset(reset), .kbd(kbd), .clear(clear), .entry_en(entry_en),
        .take(take), .min_bcd(min_bcd), .sec_tens_bcd(sec_tens_bcd),
        .sec_ones_bcd(sec_ones_bcd), .digit_cnt(digit_cnt), .time_valid(time_valid),
        .key_strobe(key_strobe), .key_code(key_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] code;
        logic [3:0] mn;
        logic [3:0] st;
        logic [3:0] so;
        logic [1:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       got_e, exp_e;
    int         checks = 0;
    int         failures = 0;
    int         strobes = 0;
    logic [3:0] m_min = 4'd0, m_st = 4'd0, m_so = 4'd0;
    logic [1:0] m_cnt = 2'd0;

    // Scoreboard consumer: every strobe must match the next expected keystroke.
    always @(negedge clk) begin
        if (key_strobe === 1'b1) begin
            strobes = strobes + 1;
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_strobe got key_code=%0d want no strobe", key_code);
            end else begin
                exp_e = sb_q.pop_front();
                got_e = {key_code, min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt};
                if (got_e !== exp_e) begin
                    failures = failures + 1;
                    $display("FAIL strobe_state got code/min/st/so/cnt=%h want=%h", got_e, exp_e);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        m_min = 4'd0; m_st = 4'd0; m_so = 4'd0; m_cnt = 2'd0;
    endtask

    task automatic push_exp(input logic [3:0] d);
        sb_q.push_back({d, m_min, m_st, m_so, m_cnt});
    endtask

    task automatic model_shift(input logic [3:0] d);
        m_min = m_st; m_st = m_so; m_so = d;
        if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        push_exp(d);
    endtask

    task automatic press(input int d, input int hold, input int rel);
        kbd = 10'd1 << d;
        cycles(hold);
        kbd = 10'd0;
        cycles(rel);
    endtask

    task automatic key(input int d);
        if (entry_en) model_shift(4'(d));
        else push_exp(4'(d));
        press(d, 4, 4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        model_zero();
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid, key_strobe, key_code} !== 24'd0) begin
            failures = failures + 1;
            $display("FAIL reset_state got min=%0d st=%0d so=%0d cnt=%0d tv=%0d strobe=%0d code=%0d want all 0",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid, key_strobe, key_code);
        end
    endtask

    task automatic test_two_keys();
        int s0;
        s0 = strobes;
        key(1);
        key(2);
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid} !== {4'd0, 4'd1, 4'd2, 2'd2, 1'b1}) begin
            failures = failures + 1;
            $display("FAIL two_keys_buffer got %0d:%0d%0d cnt=%0d tv=%0d want 0:12 cnt=2 tv=1",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid);
        end
        checks = checks + 1;
        if (strobes - s0 !== 2) begin
            failures = failures + 1;
            $display("FAIL two_keys_strobes got %0d want 2", strobes - s0);
        end
    endtask

    task automatic test_take();
        key(1); key(2); key(9);
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid} !== {4'd1, 4'd2, 4'd9, 2'd3, 1'b1}) begin
            failures = failures + 1;
            $display("FAIL take_before got %0d:%0d%0d cnt=%0d tv=%0d want 1:29 cnt=3 tv=1",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid);
        end
        take = 1'b1;
        cycles(1);
        take = 1'b0;
        model_zero();
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid} !== 15'd0) begin
            failures = failures + 1;
            $display("FAIL take_after got %0d:%0d%0d cnt=%0d tv=%0d want 0:00 cnt=0 tv=0",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid);
        end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = strobes;
        kbd = 10'd1 << 3;
        cycles(1);
        kbd = 10'd0;
        cycles(6);
        checks = checks + 1;
        if (strobes != s0 || {min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt} !== 14'd0) begin
            failures = failures + 1;
            $display("FAIL glitch got strobes=%0d buf=%0d:%0d%0d want strobes=0 buf=0:00",
                     strobes - s0, min_bcd, sec_tens_bcd, sec_ones_bcd);
        end
        kbd = (10'd1 << 3) | (10'd1 << 5);
        cycles(8);
        kbd = 10'd0;
        cycles(6);
        checks = checks + 1;
        if (strobes != s0) begin
            failures = failures + 1;
            $display("FAIL multi_key got strobes=%0d want 0", strobes - s0);
        end
        key(4);
        checks = checks + 1;
        if (strobes != s0 + 1) begin
            failures = failures + 1;
            $display("FAIL after_blocked got strobes=%0d want 1", strobes - s0);
        end
    endtask

    task automatic test_hold();
        int s0;
        s0 = strobes;
        model_shift(4'd5);
        kbd = 10'd1 << 5;
        cycles(20);
        kbd = 10'd0;
        cycles(1);
        kbd = 10'd1 << 5;
        cycles(1);
        kbd = 10'd0;
        cycles(6);
        checks = checks + 1;
        if (strobes != s0 + 1 || key_code !== 4'd5) begin
            failures = failures + 1;
            $display("FAIL hold_bounce got strobes=%0d code=%0d want strobes=1 code=5", strobes - s0, key_code);
        end
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt} !== {4'd0, 4'd4, 4'd5, 2'd2}) begin
            failures = failures + 1;
            $display("FAIL hold_buffer got %0d:%0d%0d cnt=%0d want 0:45 cnt=2",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt);
        end
    endtask

    task automatic test_entry_disable();
        entry_en = 1'b0;
        key(7);
        checks = checks + 1;
        if ({key_code, min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt} !== {4'd7, 4'd0, 4'd4, 4'd5, 2'd2}) begin
            failures = failures + 1;
            $display("FAIL entry_disabled got code=%0d buf=%0d:%0d%0d cnt=%0d want code=7 buf=0:45 cnt=2",
                     key_code, min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt);
        end
        entry_en = 1'b1;
        key(1); key(2); key(3); key(4);
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid} !== {4'd2, 4'd3, 4'd4, 2'd3, 1'b1}) begin
            failures = failures + 1;
            $display("FAIL overflow got %0d:%0d%0d cnt=%0d tv=%0d want 2:34 cnt=3 tv=1",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid);
        end
        key(7); key(5);
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, time_valid} !== {4'd4, 4'd7, 4'd5, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL invalid_secs got %0d:%0d%0d tv=%0d want 4:75 tv=0",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, time_valid);
        end
    endtask

    task automatic test_simultaneous();
        // Accept happens on the third edge after kbd is driven; hit it with clear.
        kbd = 10'd1 << 9;
        cycles(2);
        clear = 1'b1;
        model_zero();
        push_exp(4'd9);
        cycles(1);
        clear = 1'b0;
        cycles(3);
        kbd = 10'd0;
        cycles(4);
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, time_valid} !== 15'd0) begin
            failures = failures + 1;
            $display("FAIL clear_on_accept got %0d:%0d%0d cnt=%0d want 0:00 cnt=0",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt);
        end
        key(3);
        kbd = 10'd1 << 8;
        cycles(2);
        take = 1'b1;
        model_zero();
        model_shift(4'd8);
        cycles(1);
        take = 1'b0;
        cycles(3);
        kbd = 10'd0;
        cycles(4);
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt} !== {4'd0, 4'd0, 4'd8, 2'd1}) begin
            failures = failures + 1;
            $display("FAIL take_on_accept got %0d:%0d%0d cnt=%0d want 0:08 cnt=1",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt);
        end
        model_shift(4'd6);
        kbd = 10'd1 << 6;
        cycles(6);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        model_zero();
        checks = checks + 1;
        if ({min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, key_strobe, key_code} !== 23'd0) begin
            failures = failures + 1;
            $display("FAIL reset_held got buf=%0d:%0d%0d cnt=%0d strobe=%0d code=%0d want all 0",
                     min_bcd, sec_tens_bcd, sec_ones_bcd, digit_cnt, key_strobe, key_code);
        end
        model_shift(4'd6);
        for (int k = 1; k <= 3; k++) begin
            cycles(1);
            checks = checks + 1;
            if (key_strobe !== (k == 3)) begin
                failures = failures + 1;
                $display("FAIL reset_repress edge=%0d got strobe=%0d want %0d", k, key_strobe, (k == 3));
            end
        end
        kbd = 10'd0;
        cycles(5);
    endtask

    initial begin
        cycles(1);
        test_reset();
        test_two_keys();
        test_take();
        test_glitch();
        test_hold();
        test_entry_disable();
        test_simultaneous();
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL missing_strobes got pending=%0d want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
